clock_set_ctrl: RTL and testbench

//  Mode/set controller for the century-clock counter chain (sec -> min -> hour -> day).
//  RUN mode: forwards the 1 Hz tick and inter-stage carries as stage enables.
//  SET_HH / SET_MM modes: freezes time, steps one field per inc press (with auto-repeat),

---
 rtl/clock_pkg.sv | 12 +
 rtl/clock_set_ctrl_if.sv | 29 ++
 rtl/btn_repeat.sv | 66 ++++++
 rtl/clock_set_ctrl.sv | 138 +++++++++++++
 tb/tb_clock_set_ctrl.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared mode encodings for the century-clock set controller.
package clock_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_RUN    = 2'b00,
    MODE_SET_HH = 2'b01,
    MODE_SET_MM = 2'b10
  } mode_e;

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button, tick and carry inputs plus stage-enable and display outputs of the set controller.
interface clock_set_ctrl_if;
  import clock_pkg::*;

  logic              tick_1hz;
  logic              btn_mode;
  logic              btn_inc;
  logic              ss_to_mm_en;
  logic              mm_to_hh_en;
  logic              hh_to_dd_en;
  logic              sec_en;
  logic              min_en;
  logic              hour_en;
  logic              day_en;
  logic              sec_clr;
  logic [MODE_W-1:0] mode;
  logic              blink;

  modport master (
    output tick_1hz, btn_mode, btn_inc, ss_to_mm_en, mm_to_hh_en, hh_to_dd_en,
    input  sec_en, min_en, hour_en, day_en, sec_clr, mode, blink
  );

  modport slave (
    input  tick_1hz, btn_mode, btn_inc, ss_to_mm_en, mm_to_hh_en, hh_to_dd_en,
    output sec_en, min_en, hour_en, day_en, sec_clr, mode, blink
  );

endinterface

// File: rtl/btn_repeat.sv
// Rising-edge press detector with hold-to-repeat; emits one-cycle registered pulses.
module btn_repeat #(
  parameter int HOLD_CYC = 25_000_000,
  parameter int RPT_CYC  = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic clr,
  output logic pulse
);

  localparam int              CNT_W      = $clog2(HOLD_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYC - RPT_CYC);

  logic             btn_q, btn_d;
  logic             armed_q, armed_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_s;

  assign rise_s = btn & ~btn_q;

  // Only a fresh press arms the repeat, so a button held across clr stays silent.
  always_comb begin
    btn_d   = btn;
    armed_d = armed_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (clr || !btn) begin
      armed_d = 1'b0;
      cnt_d   = {CNT_W{1'b0}};
    end else if (rise_s) begin
      armed_d = 1'b1;
      cnt_d   = {CNT_W{1'b0}};
      pulse_d = 1'b1;
    end else if (armed_q) begin
      if (cnt_q == CNT_LAST) begin
        pulse_d = 1'b1;
        cnt_d   = CNT_RELOAD;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_q   <= 1'b0;
      armed_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      btn_q   <= btn_d;
      armed_q <= armed_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode/set controller for the sec -> min -> hour -> day chain: RUN passthrough,
// SET_HH / SET_MM single-field stepping with auto-repeat and idle timeout.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int HOLD_CYC  = 25_000_000,
  parameter int RPT_CYC   = 5_000_000,
  parameter int TIMEOUT_S = 10
) (
  input  logic             clk,
  input  logic             rst,
  clock_set_ctrl_if.slave  bus
);

  localparam int              TO_W    = $clog2(TIMEOUT_S + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_S - 1);

  mode_e           state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            sec_clr_q, sec_clr_d;
  logic            blink_q, blink_d;
  logic            mode_btn_q, mode_btn_d;
  logic            mode_rise_s;
  logic            inc_clr_s;
  logic            inc_pulse_s;
  logic            sec_en_s, min_en_s, hour_en_s, day_en_s;

  assign mode_rise_s = bus.btn_mode & ~mode_btn_q;
  // Outside SET states, and on any mode press, the inc press is discarded and disarmed.
  assign inc_clr_s   = mode_rise_s | ((state_q != MODE_SET_HH) && (state_q != MODE_SET_MM));

  btn_repeat #(
    .HOLD_CYC (HOLD_CYC),
    .RPT_CYC  (RPT_CYC)
  ) u_inc_repeat (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.btn_inc),
    .clr   (inc_clr_s),
    .pulse (inc_pulse_s)
  );

  always_comb begin
    state_d    = state_q;
    to_cnt_d   = to_cnt_q;
    sec_clr_d  = 1'b0;
    blink_d    = blink_q;
    mode_btn_d = bus.btn_mode;
    case (state_q)
      MODE_RUN: begin
        to_cnt_d = {TO_W{1'b0}};
        if (mode_rise_s) state_d = MODE_SET_HH;
        else             state_d = MODE_RUN;
      end
      MODE_SET_HH, MODE_SET_MM: begin
        if (mode_rise_s) begin
          to_cnt_d  = {TO_W{1'b0}};
          state_d   = (state_q == MODE_SET_HH) ? MODE_SET_MM : MODE_RUN;
          sec_clr_d = (state_q == MODE_SET_MM);
        end else if (bus.btn_inc) begin
          // Held inc counts as continuous activity for the idle timeout.
          to_cnt_d = {TO_W{1'b0}};
        end else if (bus.tick_1hz) begin
          if (to_cnt_q == TO_LAST) begin
            state_d   = MODE_RUN;
            to_cnt_d  = {TO_W{1'b0}};
            sec_clr_d = (state_q == MODE_SET_MM);
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end else begin
          to_cnt_d = to_cnt_q;
        end
      end
      default: begin
        state_d  = MODE_RUN;
        to_cnt_d = {TO_W{1'b0}};
      end
    endcase
    if (state_d == MODE_RUN)       blink_d = 1'b1;
    else if (state_d != state_q)   blink_d = 1'b1;
    else if (bus.tick_1hz)         blink_d = ~blink_q;
    else                           blink_d = blink_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= MODE_RUN;
      to_cnt_q   <= {TO_W{1'b0}};
      sec_clr_q  <= 1'b0;
      blink_q    <= 1'b1;
      mode_btn_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      to_cnt_q   <= to_cnt_d;
      sec_clr_q  <= sec_clr_d;
      blink_q    <= blink_d;
      mode_btn_q <= mode_btn_d;
    end
  end

  // Stage enables are combinational so RUN carries ripple through with no added latency.
  always_comb begin
    sec_en_s  = 1'b0;
    min_en_s  = 1'b0;
    hour_en_s = 1'b0;
    day_en_s  = 1'b0;
    if (!rst) begin
      sec_en_s  = 1'b0;
    end else begin
      case (state_q)
        MODE_RUN: begin
          sec_en_s  = bus.tick_1hz;
          min_en_s  = bus.ss_to_mm_en;
          hour_en_s = bus.mm_to_hh_en;
          day_en_s  = bus.hh_to_dd_en;
        end
        MODE_SET_HH: hour_en_s = inc_pulse_s;
        MODE_SET_MM: min_en_s  = inc_pulse_s;
        default: begin
          sec_en_s  = bus.tick_1hz;
          min_en_s  = bus.ss_to_mm_en;
          hour_en_s = bus.mm_to_hh_en;
          day_en_s  = bus.hh_to_dd_en;
        end
      endcase
    end
  end

  assign bus.sec_en  = sec_en_s;
  assign bus.min_en  = min_en_s;
  assign bus.hour_en = hour_en_s;
  assign bus.day_en  = day_en_s;
  assign bus.sec_clr = sec_clr_q;
  assign bus.mode    = state_q;
  assign bus.blink   = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl; expected output vectors go through a scoreboard queue.
module tb_clock_set_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  clock_set_ctrl_if bus();

  clock_set_ctrl #(
    .HOLD_CYC  (4),
    .RPT_CYC   (2),
    .TIMEOUT_S (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Expected vector layout: {mode[1:0], sec_en, min_en, hour_en, day_en, sec_clr, blink}
  function automatic logic [7:0] ex(input int m, input int s, input int mi, input int h,
                                    input int d, input int c, input int b);
    return {m[1:0], s[0], mi[0], h[0], d[0], c[0], b[0]};
  endfunction

  task automatic set_in(input int t, input int bm, input int bi,
                        input int c1, input int c2, input int c3);
    bus.tick_1hz    = t[0];
    bus.btn_mode    = bm[0];
    bus.btn_inc     = bi[0];
    bus.ss_to_mm_en = c1[0];
    bus.mm_to_hh_en = c2[0];
    bus.hh_to_dd_en = c3[0];
  endtask

  // Push the expectation for the current cycle, compare at negedge, advance to posedge+1.
  task automatic cyc(input string tag, input logic [7:0] e);
    logic [7:0] obs;
    logic [7:0] want;
    string      t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    obs  = {bus.mode, bus.sec_en, bus.min_en, bus.hour_en, bus.day_en, bus.sec_clr, bus.blink};
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (mode,sec,min,hour,day,clr,blink)", t, obs, want);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    set_in(1, 0, 0, 1, 1, 1);
    @(posedge clk);
    #1;
    // 1. reset with tick and carries high
    cyc("rst_hold",  ex(0, 0, 0, 0, 0, 0, 1));
    cyc("rst_hold2", ex(0, 0, 0, 0, 0, 0, 1));
    rst = 1'b1;
    cyc("run_pass",  ex(0, 1, 1, 1, 1, 0, 1));
    // 2. RUN zero-latency passthrough
    set_in(0, 0, 0, 0, 0, 0); cyc("run_idle", ex(0, 0, 0, 0, 0, 0, 1));
    set_in(1, 0, 0, 0, 0, 0); cyc("run_tick", ex(0, 1, 0, 0, 0, 0, 1));
    set_in(0, 0, 0, 0, 0, 1); cyc("run_day",  ex(0, 0, 0, 0, 1, 0, 1));
    set_in(0, 0, 0, 0, 1, 0); cyc("run_hour", ex(0, 0, 0, 1, 0, 0, 1));
    // 3. enter SET_HH, single inc at hour 23 with day carry fed back
    set_in(0, 1, 0, 0, 0, 0); cyc("mode_press",     ex(0, 0, 0, 0, 0, 0, 1));
    set_in(0, 0, 0, 0, 0, 0); cyc("enter_hh",       ex(1, 0, 0, 0, 0, 0, 1));
    set_in(0, 0, 1, 0, 0, 1); cyc("hh_inc_press",   ex(1, 0, 0, 0, 0, 0, 1));
    set_in(0, 0, 0, 0, 0, 1); cyc("hh_inc_step",    ex(1, 0, 0, 1, 0, 0, 1));
    set_in(0, 0, 0, 0, 0, 0); cyc("hh_inc_once",    ex(1, 0, 0, 0, 0, 0, 1));
    set_in(1, 0, 0, 0, 0, 0); cyc("hh_tick_frozen", ex(1, 0, 0, 0, 0, 0, 1));
    set_in(0, 0, 0, 0, 0, 0); cyc("hh_blink_tog",   ex(1, 0, 0, 0, 0, 0, 0));
    // 4. hold inc 10 cycles: pulses at press+1, +5, +7, +9
    for (int k = 0; k < 14; k++) begin
      set_in(0, 0, int'(k < 10), 0, 0, 0);
      cyc($sformatf("hh_repeat_%0d", k),
          ex(1, 0, 0, int'(k == 1 || k == 5 || k == 7 || k == 9), 0, 0, 0));
    end
    // 5a. SET_MM idle timeout pulses sec_clr once
    set_in(0, 1, 0, 0, 0, 0); cyc("mode_press2", ex(1, 0, 0, 0, 0, 0, 0));
    set_in(0, 0, 0, 0, 0, 0); cyc("enter_mm",    ex(2, 0, 0, 0, 0, 0, 1));
    set_in(1, 0, 0, 0, 0, 0); cyc("mm_tick1",    ex(2, 0, 0, 0, 0, 0, 1));
    set_in(0, 0, 0, 0, 0, 0); cyc("mm_gap1",     ex(2, 0, 0, 0, 0, 0, 0));
    set_in(1, 0, 0, 0, 0, 0); cyc("mm_tick2",    ex(2, 0, 0, 0, 0, 0, 0));
    set_in(0, 0, 0, 0, 0, 0); cyc("mm_gap2",     ex(2, 0, 0, 0, 0, 0, 1));
    set_in(1, 0, 0, 0, 0, 0); cyc("mm_tick3",    ex(2, 0, 0, 0, 0, 0, 1));
    set_in(0, 0, 0, 0, 0, 0); cyc("mm_timeout",  ex(0, 0, 0, 0, 0, 1, 1));
    cyc("mm_clr_once", ex(0, 0, 0, 0, 0, 0, 1));
    // 5b. SET_HH timeout, press on tick 2 restarts the count, no sec_clr
    set_in(0, 1, 0, 0, 0, 0); cyc("mode_press3",     ex(0, 0, 0, 0, 0, 0, 1));
    set_in(0, 0, 0, 0, 0, 0); cyc("enter_hh2",       ex(1, 0, 0, 0, 0, 0, 1));
    set_in(1, 0, 0, 0, 0, 0); cyc("hh2_tick1",       ex(1, 0, 0, 0, 0, 0, 1));
    set_in(0, 0, 0, 0, 0, 0); cyc("hh2_gap1",        ex(1, 0, 0, 0, 0, 0, 0));
    set_in(1, 0, 1, 0, 0, 0); cyc("hh2_tick2_press", ex(1, 0, 0, 0, 0, 0, 0));
    set_in(0, 0, 0, 0, 0, 0); cyc("hh2_press_step",  ex(1, 0, 0, 1, 0, 0, 1));
    set_in(1, 0, 0, 0, 0, 0); cyc("hh2_tick3",       ex(1, 0, 0, 0, 0, 0, 1));
    set_in(0, 0, 0, 0, 0, 0); cyc("hh2_restarted",   ex(1, 0, 0, 0, 0, 0, 0));
    set_in(1, 0, 0, 0, 0, 0); cyc("hh2_tick4",       ex(1, 0, 0, 0, 0, 0, 0));
    set_in(0, 0, 0, 0, 0, 0); cyc("hh2_gap4",        ex(1, 0, 0, 0, 0, 0, 1));
    set_in(1, 0, 0, 0, 0, 0); cyc("hh2_tick5",       ex(1, 0, 0, 0, 0, 0, 1));
    set_in(0, 0, 0, 0, 0, 0); cyc("hh_timeout_noclr", ex(0, 0, 0, 0, 0, 0, 1));
    // 6. simultaneous mode+inc rise: mode wins, held inc does not repeat
    set_in(0, 1, 0, 0, 0, 0); cyc("mode_press4",   ex(0, 0, 0, 0, 0, 0, 1));
    set_in(0, 0, 0, 0, 0, 0); cyc("enter_hh3",     ex(1, 0, 0, 0, 0, 0, 1));
    set_in(0, 1, 1, 0, 0, 0); cyc("mode_inc_same", ex(1, 0, 0, 0, 0, 0, 1));
    for (int k = 0; k < 8; k++) begin
      set_in(0, 0, 1, 0, 0, 0);
      cyc($sformatf("mm_held_norepeat_%0d", k), ex(2, 0, 0, 0, 0, 0, 1));
    end
    set_in(0, 0, 0, 0, 0, 0); cyc("mm_release",   ex(2, 0, 0, 0, 0, 0, 1));
    set_in(0, 0, 1, 0, 1, 0); cyc("mm_inc_press", ex(2, 0, 0, 0, 0, 0, 1));
    set_in(0, 0, 1, 0, 1, 0); cyc("mm_inc_step",  ex(2, 0, 1, 0, 0, 0, 1));
    set_in(0, 0, 1, 0, 0, 0); cyc("mm_hold_a",    ex(2, 0, 0, 0, 0, 0, 1));
    set_in(0, 0, 1, 0, 0, 0); cyc("mm_hold_b",    ex(2, 0, 0, 0, 0, 0, 1));
    // reset asserted mid-hold
    rst = 1'b0;
    set_in(1, 0, 1, 1, 1, 1); cyc("rst_mid_hold",  ex(0, 0, 0, 0, 0, 0, 1));
    cyc("rst_mid_hold2", ex(0, 0, 0, 0, 0, 0, 1));
    rst = 1'b1;
    set_in(0, 0, 1, 0, 0, 0); cyc("after_rst_a", ex(0, 0, 0, 0, 0, 0, 1));
    cyc("after_rst_b", ex(0, 0, 0, 0, 0, 0, 1));
    cyc("after_rst_c", ex(0, 0, 0, 0, 0, 0, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
